// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: parity modes, frame FSM state
// encoding and a width helper for the bit-timing and bit-index counters.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Word handshake between the transmit holding register (master) and the
// UART transmit engine (slave).
interface uart_tx_engine_if #(
    parameter int DATA_BITS = 8
);

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts clk cycles while enabled and flags the last cycle
// of every serial bit. Shared by the transmitter and the receiver.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam int               CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign tick = enable && (count == CNT_LAST);

    // Free-running bit counter, realigned to zero when a new frame starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: accepts one word over a valid/ready handshake and sends
// start bit, DATA_BITS data bits LSB first, optional parity and 1 or 2 stop
// bits on a registered, idle-high txd line.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_engine_if.slave    tx,
    input  logic [1:0]         parity_mode,
    input  logic               two_stop,
    output logic               txd,
    output logic               busy,
    output logic               done
);

    localparam int               IDX_W    = cnt_width(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic [2:0]           state;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 parity_bit;
    logic                 parity_en;
    logic                 two_stop_q;
    logic                 tick;
    logic                 accept;
    logic                 stop_last;

    assign tx.tx_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign accept      = tx.tx_valid && (state == IDLE);
    assign stop_last   = (stop_idx == two_stop_q);
    assign done        = (state == STOP) && tick && stop_last;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (accept),
        .enable  (busy),
        .tick    (tick)
    );

    // Frame sequencer; txd is loaded with the value of the bit being entered
    // so the line changes exactly on bit boundaries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            txd      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= START;
                        txd   <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        txd     <= shreg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            if (parity_en) begin
                                state <= PARITY;
                                txd   <= parity_bit;
                            end else begin
                                state    <= STOP;
                                stop_idx <= 1'b0;
                                txd      <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            txd     <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state    <= STOP;
                        stop_idx <= 1'b0;
                        txd      <= 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (stop_last) begin
                            state    <= IDLE;
                            stop_idx <= 1'b0;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

    // Frame payload and settings captured at accept, so later input changes
    // cannot disturb the frame in flight; data shifts out LSB first.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg      <= tx.tx_data;
            parity_en  <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
            parity_bit <= (^tx.tx_data) ^ (parity_mode == PAR_ODD);
            two_stop_q <= two_stop;
        end else if ((state == DATA) && tick) begin
            shreg <= shreg >> 1;
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: expected line bits are queued when a
// word is offered and popped cycle by cycle as the frame goes out.
module tb_uart_tx_engine;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_engine_if #(.DATA_BITS(8)) bus_a ();
    uart_tx_engine_if #(.DATA_BITS(5)) bus_b ();

    logic [1:0] mode_a, mode_b;
    logic       two_a, two_b;
    logic       txd_a, busy_a, done_a;
    logic       txd_b, busy_b, done_b;

    uart_tx_engine #(.DATA_BITS(8), .CLKS_PER_BIT(4)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .tx          (bus_a),
        .parity_mode (mode_a),
        .two_stop    (two_a),
        .txd         (txd_a),
        .busy        (busy_a),
        .done        (done_a)
    );

    uart_tx_engine #(.DATA_BITS(5), .CLKS_PER_BIT(3)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .tx          (bus_b),
        .parity_mode (mode_b),
        .two_stop    (two_b),
        .txd         (txd_b),
        .busy        (busy_b),
        .done        (done_b)
    );

    logic use_b;
    logic cur_txd, cur_busy, cur_done, cur_ready;
    assign cur_txd   = use_b ? txd_b  : txd_a;
    assign cur_busy  = use_b ? busy_b : busy_a;
    assign cur_done  = use_b ? done_b : done_a;
    assign cur_ready = use_b ? bus_b.tx_ready : bus_a.tx_ready;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected line sequence for one frame, built from the frame format.
    task automatic push_frame(input logic [8:0] d, input logic [1:0] m, input logic two);
        int   nbits;
        logic p;
        exp_t e;
        nbits = use_b ? 5 : 8;
        p = 1'b0;
        e.last = 1'b0;
        e.b = 1'b0;
        exp_q.push_back(e);
        for (int i = 0; i < nbits; i++) begin
            e.b = d[i];
            p   = p ^ d[i];
            exp_q.push_back(e);
        end
        if (m == 2'b01) begin
            e.b = p;
            exp_q.push_back(e);
        end else if (m == 2'b10) begin
            e.b = ~p;
            exp_q.push_back(e);
        end
        e.b = 1'b1;
        e.last = !two;
        exp_q.push_back(e);
        if (two) begin
            e.last = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Offer a word at a negedge; the accept edge is the following posedge.
    task automatic offer(input string name, input logic [8:0] d, input logic [1:0] m, input logic two);
        check({name, ".ready_before"}, cur_ready, 1'b1);
        if (use_b) begin
            bus_b.tx_data  = d[4:0];
            mode_b         = m;
            two_b          = two;
            bus_b.tx_valid = 1'b1;
        end else begin
            bus_a.tx_data  = d[7:0];
            mode_a         = m;
            two_a          = two;
            bus_a.tx_valid = 1'b1;
        end
        push_frame(d, m, two);
    endtask

    // Drop valid and scramble every input, which the engine must ignore.
    task automatic release_inputs();
        if (use_b) begin
            bus_b.tx_valid = 1'b0;
            bus_b.tx_data  = ~bus_b.tx_data;
            mode_b         = ~mode_b;
            two_b          = ~two_b;
        end else begin
            bus_a.tx_valid = 1'b0;
            bus_a.tx_data  = ~bus_a.tx_data;
            mode_a         = ~mode_a;
            two_a          = ~two_a;
        end
    endtask

    // Called at the negedge of cycle 1 after the accept edge; returns at the
    // negedge of the idle cycle that follows the frame.
    task automatic run_frame(input string name, input int len_exp);
        exp_t e;
        int   clks;
        int   busy_cnt;
        clks = use_b ? 3 : 4;
        busy_cnt = 0;
        forever begin
            check({name, ".sb_nonempty"}, (exp_q.size() != 0), 1'b1);
            if (exp_q.size() == 0) return;
            e = exp_q.pop_front();
            for (int c = 0; c < clks; c++) begin
                check({name, ".txd"}, cur_txd, e.b);
                check({name, ".ready_busy"}, cur_ready, 1'b0);
                check({name, ".done"}, cur_done, (e.last && (c == clks - 1)));
                if (cur_busy === 1'b1) busy_cnt++;
                @(negedge clk);
            end
            if (e.last) break;
        end
        check({name, ".busy_len"}, busy_cnt, len_exp);
        check({name, ".idle_txd"}, cur_txd, 1'b1);
        check({name, ".idle_busy"}, cur_busy, 1'b0);
        check({name, ".idle_ready"}, cur_ready, 1'b1);
        check({name, ".idle_done"}, cur_done, 1'b0);
    endtask

    task automatic frame(input string name, input logic [8:0] d, input logic [1:0] m,
                         input logic two, input int len_exp);
        offer(name, d, m, two);
        @(negedge clk);
        release_inputs();
        run_frame(name, len_exp);
    endtask

    initial begin
        reset = 1'b1;
        use_b = 1'b0;
        bus_a.tx_valid = 1'b0;
        bus_a.tx_data  = '0;
        bus_b.tx_valid = 1'b0;
        bus_b.tx_data  = '0;
        mode_a = 2'b00; two_a = 1'b0;
        mode_b = 2'b00; two_b = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.txd_a", txd_a, 1'b1);
        check("rst.ready_a", bus_a.tx_ready, 1'b1);
        check("rst.busy_a", busy_a, 1'b0);
        check("rst.done_a", done_a, 1'b0);
        check("rst.txd_b", txd_b, 1'b1);
        check("rst.busy_b", busy_b, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        frame("a5_none_1stop", 9'h0A5, 2'b00, 1'b0, 40);
        frame("a5_even_2stop", 9'h0A5, 2'b01, 1'b1, 48);
        frame("07_odd", 9'h007, 2'b10, 1'b0, 44);
        frame("03_odd", 9'h003, 2'b10, 1'b0, 44);
        frame("03_mode11", 9'h003, 2'b11, 1'b0, 40);

        // Back-to-back with valid held high; data changes under the frame.
        offer("b2b_55", 9'h055, 2'b00, 1'b0);
        @(negedge clk);
        bus_a.tx_data = 8'hAA;
        push_frame(9'h0AA, 2'b00, 1'b0);
        run_frame("b2b_55", 40);
        @(negedge clk);
        bus_a.tx_valid = 1'b0;
        bus_a.tx_data  = 8'h00;
        run_frame("b2b_aa", 40);

        // Reset in the middle of a frame.
        offer("rst_mid", 9'h000, 2'b01, 1'b1);
        @(negedge clk);
        release_inputs();
        repeat (10) @(negedge clk);
        check("rst_mid.pre_txd", txd_a, 1'b0);
        check("rst_mid.pre_busy", busy_a, 1'b1);
        exp_q.delete();
        #1 reset = 1'b1;
        #1;
        check("rst_mid.async_txd", txd_a, 1'b1);
        check("rst_mid.async_busy", busy_a, 1'b0);
        check("rst_mid.async_ready", bus_a.tx_ready, 1'b1);
        check("rst_mid.async_done", done_a, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid.hold_done", done_a, 1'b0);
            check("rst_mid.hold_txd", txd_a, 1'b1);
        end
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid.after_done", done_a, 1'b0);
        frame("after_rst_3c", 9'h03C, 2'b00, 1'b0, 40);

        // Narrow configuration: 5 data bits, 3 clocks per bit.
        use_b = 1'b1;
        @(negedge clk);
        frame("b_1f", 9'h01F, 2'b00, 1'b0, 21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
